// File: rtl/wait_merge_n.sv
// N-channel wait-merge (join): one holding register per input channel, concatenated
// output on a valid/ready handshake, runtime enable mask and a stall watchdog.

module wait_merge_ch #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_mask,
  input  logic                  i_fire,
  output logic                  o_free,
  output logic                  o_held,
  output logic [DATA_WIDTH-1:0] o_dreg
);
  logic                  held_q, held_d;
  logic [DATA_WIDTH-1:0] dreg_q, dreg_d;

  // A consumed slot can be refilled in the same cycle, giving one merge per cycle.
  assign o_free = ~held_q | (i_fire & i_mask);
  assign o_held = held_q;
  assign o_dreg = dreg_q;

  always_comb begin
    held_d = held_q;
    dreg_d = dreg_q;
    if (i_fire && i_mask) held_d = 1'b0;
    if (i_drive && o_free) begin
      held_d = 1'b1;
      dreg_d = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= 1'b0;
      dreg_q <= '0;
    end else begin
      held_q <= held_d;
      dreg_q <= dreg_d;
    end
  end
endmodule

module wait_merge_n #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              i_drive,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_data,
  output logic [NUM_CH-1:0]              o_free,
  input  logic [NUM_CH-1:0]              i_mask,
  output logic                           o_driveNext,
  output logic [NUM_CH*DATA_WIDTH-1:0]   o_data,
  input  logic                           i_freeNext,
  output logic                           o_stall_err,
  input  logic                           i_err_clr
);
  logic [NUM_CH-1:0]                 held;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] dreg;
  logic                              fire;
  logic                              out_valid_q, out_valid_d;
  logic [NUM_CH*DATA_WIDTH-1:0]      out_data_q, out_data_d;

  assign fire = (|i_mask) & (&(held | ~i_mask)) & (~out_valid_q | i_freeNext);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    wait_merge_ch #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_drive(i_drive[k]),
      .i_data (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .i_mask (i_mask[k]),
      .i_fire (fire),
      .o_free (o_free[k]),
      .o_held (held[k]),
      .o_dreg (dreg[k])
    );
  end

  // Masked slots are zeroed in the output; their held tokens wait for unmasking.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (fire) begin
      out_valid_d = 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = i_mask[k] ? dreg[k] : '0;
    end else if (i_freeNext && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign o_driveNext = out_valid_q;
  assign o_data      = out_data_q;

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          any_held, stall_inc;

    // Only stalls caused by missing inputs count; pure downstream backpressure holds.
    assign any_held  = |(held & i_mask);
    assign stall_inc = any_held & ~fire & (~out_valid_q | i_freeNext);

    always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (fire || !any_held)                cnt_d = '0;
      else if (stall_inc && cnt_q != TO_MAX) cnt_d = cnt_q + CW'(1);
      if (i_err_clr)                             err_d = 1'b0;
      if (stall_inc && cnt_q == TO_MAX - CW'(1)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign o_stall_err = err_q;
  end else begin : g_no_wd
    assign o_stall_err = 1'b0;
  end
endmodule
